con_unit_p: RTL and testbench

- Parametrised branch-condition unit that succeeds the single-operand CON flip-flop in the Mini SRC datapath.
- Evaluates branch conditions on bus values of width WIDTH and registers the result as CON for the control unit's PC-load decision.
- Adds new conditions: always, never, signed and unsigned two-operand compares, and an illegal-code flag.
- Because the datapath has a single bus, a two-operand compare captures operand A on one strobe and operand B on a later strobe, sequenced by a small FSM.

---
 rtl/con_pkg.sv | 11 +
 rtl/con_eval.sv | 41 ++++
 rtl/con_unit_p.sv | 64 ++++++
 tb/tb_con_unit_p.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/con_pkg.sv
// con_pkg: condition codes, FSM encoding and code classification shared by the CON unit.
package con_pkg;
    localparam logic [3:0] COND_ZR = 4'd0, COND_NZ = 4'd1, COND_PL = 4'd2, COND_MI = 4'd3,
                           COND_AL = 4'd4, COND_NV = 4'd5, COND_GE0 = 4'd6, COND_LE0 = 4'd7,
                           COND_EQ = 4'd8, COND_NE = 4'd9, COND_LT = 4'd10, COND_GE = 4'd11,
                           COND_LTU = 4'd12, COND_GEU = 4'd13;
    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT_B = 1'b1} state_t;
    function automatic logic is_two_op(input logic [3:0] c);
        return c >= COND_EQ && c <= COND_GEU;
    endfunction
endpackage

// File: rtl/con_eval.sv
// con_eval: combinational branch-condition evaluation of A (and B for compares).
module con_eval import con_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CW = 4
) (
    input  logic [CW-1:0]    cond,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result,
    output logic             illegal
);
    logic [3:0] c;
    logic zero, neg, lts, ltu, raw;
    assign c = cond[3:0];
    assign zero = a == '0;
    assign neg = a[WIDTH-1];
    assign lts = $signed(a) < $signed(b);
    assign ltu = a < b;
    assign illegal = (|(cond >> 4)) || c > COND_GEU;
    always_comb begin
        raw = 1'b0;
        case (c)
            COND_ZR:  raw = zero;
            COND_NZ:  raw = !zero;
            COND_PL:  raw = !neg && !zero;
            COND_MI:  raw = neg;
            COND_AL:  raw = 1'b1;
            COND_NV:  raw = 1'b0;
            COND_GE0: raw = !neg;
            COND_LE0: raw = neg || zero;
            COND_EQ:  raw = a == b;
            COND_NE:  raw = a != b;
            COND_LT:  raw = lts;
            COND_GE:  raw = !lts;
            COND_LTU: raw = ltu;
            COND_GEU: raw = !ltu;
            default:  raw = 1'b0;
        endcase
    end
    assign result = raw && !illegal;
endmodule

// File: rtl/con_unit_p.sv
// con_unit_p: registered CON flag; two-operand compares take A on con_in and B on a later opb_in.
module con_unit_p import con_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CW = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             con_in,
    input  logic             opb_in,
    input  logic [CW-1:0]    cond,
    input  logic [WIDTH-1:0] bus_in,
    output logic             con_out,
    output logic             con_valid,
    output logic             busy,
    output logic             err
);
    state_t state, state_nx;
    logic [WIDTH-1:0] opa;
    logic [CW-1:0] cond_q;
    logic use_q, result, illegal, two_op, fire, done, cap;
    logic out_nx, valid_nx, err_nx;
    // A fresh command always evaluates the live bus; only a completing compare uses the captured A.
    assign use_q = state == ST_WAIT_B && !con_in;
    con_eval #(.WIDTH(WIDTH), .CW(CW)) u_eval (
        .cond(use_q ? cond_q : cond),
        .a(use_q ? opa : bus_in),
        .b(bus_in),
        .result(result),
        .illegal(illegal)
    );
    assign two_op = !illegal && is_two_op(cond[3:0]);
    assign fire = !flush && con_in;
    assign done = !flush && !con_in && state == ST_WAIT_B && opb_in;
    assign cap = fire && two_op;
    assign busy = state == ST_WAIT_B;
    always_ff @(posedge clk or posedge clr)
        if (clr) state <= ST_IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = flush ? ST_IDLE : con_in ? (two_op ? ST_WAIT_B : ST_IDLE) : done ? ST_IDLE : state;
    end
    always_comb begin
        out_nx = flush ? 1'b0 : ((fire && !two_op) || done) ? result : con_out;
        valid_nx = flush ? 1'b0 : fire ? !two_op : done ? 1'b1 : con_valid;
        err_nx = flush ? 1'b0 : fire ? illegal : err;
    end
    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            con_out <= 1'b0;
            con_valid <= 1'b0;
            err <= 1'b0;
            opa <= '0;
            cond_q <= '0;
        end else begin
            con_out <= out_nx;
            con_valid <= valid_nx;
            err <= err_nx;
            if (cap) begin
                opa <= bus_in;
                cond_q <= cond;
            end
        end
endmodule

// File: tb/tb_con_unit_p.sv
// tb_con_unit_p: directed and random checks of con_unit_p (32-bit and 8-bit instances) against a reference model.
module tb_con_unit_p;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr32, fl32, con32, opb32;
    logic [3:0] cond32;
    logic [31:0] bus32;
    logic out32, val32, busy32, err32;

    logic clr8, fl8, con8, opb8;
    logic [5:0] cond8;
    logic [7:0] bus8;
    logic out8, val8, busy8, err8;

    con_unit_p #(.WIDTH(32), .CW(4)) dut32 (
        .clk(clk), .clr(clr32), .flush(fl32), .con_in(con32), .opb_in(opb32),
        .cond(cond32), .bus_in(bus32), .con_out(out32), .con_valid(val32), .busy(busy32), .err(err32)
    );
    con_unit_p #(.WIDTH(8), .CW(6)) dut8 (
        .clk(clk), .clr(clr8), .flush(fl8), .con_in(con8), .opb_in(opb8),
        .cond(cond8), .bus_in(bus8), .con_out(out8), .con_valid(val8), .busy(busy8), .err(err8)
    );

    int total = 0;
    int bad = 0;
    logic [3:0] sb[$];
    logic last_out;

    function automatic logic slt(input logic [31:0] a, input logic [31:0] b);
        return (a[31] != b[31]) ? a[31] : (a < b);
    endfunction

    function automatic logic ref_eval(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0: return a == 0;
            4'd1: return a != 0;
            4'd2: return !a[31] && a != 0;
            4'd3: return a[31];
            4'd4: return 1'b1;
            4'd5: return 1'b0;
            4'd6: return !a[31];
            4'd7: return a[31] || a == 0;
            4'd8: return a == b;
            4'd9: return a != b;
            4'd10: return slt(a, b);
            4'd11: return !slt(a, b);
            4'd12: return a < b;
            4'd13: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input bit w8, input string tag);
        logic [3:0] e, obs;
        e = sb.pop_front();
        obs = w8 ? {out8, val8, err8, busy8} : {out32, val32, err32, busy32};
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s got{out,valid,err,busy}=%b want=%b", tag, obs, e);
        end
    endtask

    task automatic step(input bit w8, input bit ci, input bit ob, input bit fl,
                        input logic [5:0] c, input logic [31:0] b, input logic [3:0] exp, input string tag);
        if (w8) begin
            con8 = ci; opb8 = ob; fl8 = fl; cond8 = c; bus8 = b[7:0];
        end else begin
            con32 = ci; opb32 = ob; fl32 = fl; cond32 = c[3:0]; bus32 = b;
        end
        sb.push_back(exp);
        @(posedge clk);
        #1;
        con8 = 0; opb8 = 0; fl8 = 0; con32 = 0; opb32 = 0; fl32 = 0;
        check(w8, tag);
    endtask

    initial begin
        logic [3:0] c;
        logic [31:0] a, b;
        logic r;
        clr32 = 1; clr8 = 1; fl32 = 0; fl8 = 0; con32 = 0; con8 = 0; opb32 = 0; opb8 = 0;
        cond32 = 0; cond8 = 0; bus32 = 0; bus8 = 0;
        #2;
        sb.push_back(4'b0000); check(0, "reset32");
        sb.push_back(4'b0000); check(1, "reset8");
        @(negedge clk);
        clr32 = 0; clr8 = 0;

        step(0, 1, 0, 0, 0, 32'h0, 4'b1100, "zr_zero");
        step(0, 1, 0, 0, 2, 32'h8000_0000, 4'b0100, "pl_neg");
        step(0, 1, 0, 0, 10, 32'hFFFF_FFFF, 4'b0001, "lt_capture");
        step(0, 0, 0, 0, 0, 32'h0, 4'b0001, "lt_wait1");
        step(0, 0, 0, 0, 0, 32'h0, 4'b0001, "lt_wait2");
        step(0, 0, 1, 0, 0, 32'h1, 4'b1100, "lt_result");
        step(0, 1, 0, 0, 12, 32'hFFFF_FFFF, 4'b1001, "ltu_capture");
        step(0, 0, 1, 0, 0, 32'h1, 4'b0100, "ltu_result");
        step(0, 0, 1, 0, 0, 32'h0, 4'b0100, "opb_idle_ignored");
        step(0, 1, 0, 0, 14, 32'h0, 4'b0110, "illegal14");
        step(0, 1, 0, 0, 4, 32'h0, 4'b1100, "always");
        step(0, 1, 0, 0, 8, 32'h5, 4'b1001, "eq_capture");
        step(0, 1, 1, 0, 1, 32'h0, 4'b0100, "con_beats_opb");
        step(0, 1, 0, 0, 8, 32'h5, 4'b0001, "eq_capture2");
        step(0, 0, 0, 1, 0, 32'h5, 4'b0000, "flush");
        step(0, 0, 1, 0, 0, 32'h5, 4'b0000, "opb_after_flush");
        step(0, 1, 0, 0, 15, 32'h0, 4'b0110, "illegal15");

        last_out = 1'b0;
        for (int i = 0; i < 24; i++) begin
            c = 4'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            r = ref_eval(c, a, 32'h0);
            step(0, 1, 0, 0, {2'b00, c}, a, {r, 3'b100}, "single_rand");
            last_out = r;
        end
        for (int i = 0; i < 16; i++) begin
            c = 4'($urandom_range(8, 13));
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : $urandom;
            r = ref_eval(c, a, b);
            step(0, 1, 0, 0, {2'b00, c}, a, {last_out, 3'b001}, "two_op_capture");
            step(0, 0, 1, 0, 0, b, {r, 3'b100}, "two_op_result");
            last_out = r;
        end

        step(1, 1, 0, 0, 11, 32'h80, 4'b0001, "w8_ge_capture");
        step(1, 0, 1, 0, 0, 32'h7F, 4'b0100, "w8_ge_result");
        step(1, 1, 0, 0, 13, 32'h80, 4'b0001, "w8_geu_capture");
        step(1, 0, 1, 0, 0, 32'h7F, 4'b1100, "w8_geu_result");
        step(1, 1, 0, 0, 6'h11, 32'h0, 4'b0110, "w8_high_bits_illegal");
        step(1, 1, 0, 0, 6'h04, 32'h0, 4'b1100, "w8_always");
        step(1, 1, 0, 0, 8, 32'h1, 4'b1001, "w8_eq_capture");
        #3;
        clr8 = 1;
        #1;
        sb.push_back(4'b0000);
        check(1, "w8_async_clr");
        @(negedge clk);
        clr8 = 0;
        step(1, 0, 1, 0, 0, 32'h1, 4'b0000, "w8_opb_after_clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
